// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with N combinational read ports, one
// synchronous write port and a per-register scoreboard of busy bits.
// Issue marks a destination as pending; writeback stores the data and
// clears the pending bit. Register 0 always reads 0 and is never busy.
//
// Optional feature: define REG_FILE_SB_BYPASS_EN to forward a same-cycle
// writeback to any read port that reads the register being written.
// Without it, the write and its busy clear become visible after the edge.

module reg_file_sb #(
  parameter int XLEN       = 32,
  parameter int NREGS      = 32,
  parameter int NREAD      = 2,
  parameter int INIT_INDEX = 1,
  localparam int AW        = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  output logic                  hazard,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [XLEN-1:0]       wr_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush,
  output logic [AW:0]           pend_cnt
);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic [AW:0]      pop_nxt;

  // Register storage: init values on reset, writeback otherwise (reg 0 stays 0)
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= (INIT_INDEX != 0) ? XLEN'(i) : '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Next busy vector: writeback clears, issue then sets (new owner wins),
  // flush overrides both; bit 0 is forced low
  always_comb begin
    busy_nxt = busy;
    if (wr_en && (wr_addr != '0)) begin
      busy_nxt[wr_addr] = 1'b0;
    end
    if (iss_en && (iss_addr != '0)) begin
      busy_nxt[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_nxt = '0;
    end
    busy_nxt[0] = 1'b0;
  end

  // Population count of the next busy vector so pend_cnt tracks busy exactly
  always_comb begin
    pop_nxt = '0;
    for (int i = 0; i < NREGS; i++) begin
      pop_nxt = pop_nxt + {{AW{1'b0}}, busy_nxt[i]};
    end
  end

  // Scoreboard state and its pending count update on the same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy     <= '0;
      pend_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pop_nxt;
    end
  end

  // Combinational read ports, optionally forwarding the in-flight writeback
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_data[k*XLEN +: XLEN] = regs[rd_addr[k*AW +: AW]];
      rd_busy[k]              = busy[rd_addr[k*AW +: AW]];
`ifdef REG_FILE_SB_BYPASS_EN
      if (wr_en && (wr_addr != '0) && (wr_addr == rd_addr[k*AW +: AW])) begin
        rd_data[k*XLEN +: XLEN] = wr_data;
        rd_busy[k]              = iss_en && (iss_addr == wr_addr);
      end
`endif
    end
  end

  // Stall whenever any operand is still pending
  assign hazard = |rd_busy;

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb (default parameters).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        hazard;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        iss_en = 1'b0;
  logic [4:0]  iss_addr = '0;
  logic        flush = 1'b0;
  logic [5:0]  pend_cnt;

  int checks = 0;
  int failures = 0;

  reg_file_sb dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .hazard(hazard), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .pend_cnt(pend_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        ie;
    logic [4:0]  ia;
    logic        fl;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] d0;
    logic        b0;
    logic [31:0] d1;
    logic        b1;
    logic [5:0]  pc;
    string       name;
  } vec_t;

  vec_t vecs [12];

  // reference model: architectural contents and set of pending registers
  logic [31:0] m_reg [32];
  bit          m_busy [32];

  function automatic int m_pending();
    int n = 0;
    for (int i = 0; i < 32; i++) n += m_busy[i] ? 1 : 0;
    return n;
  endfunction

  initial begin
    logic [31:0] e0, e1;
    logic        eb0, eb1;
    logic [4:0]  a0, a1;

    vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd5,  1'b0, 5'd0,  5'd5, 32'h0,        1'b0, 32'h5,        1'b1, 6'd1, "iss5"};
    vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0,  1'b0, 5'd0,  5'd5, 32'h0,        1'b0, 32'hDEADBEEF, 1'b0, 6'd0, "wr5"};
    vecs[2]  = '{1'b1, 5'd7,  32'h1234,     1'b1, 5'd7,  1'b0, 5'd7,  5'd5, 32'h1234,     1'b1, 32'hDEADBEEF, 1'b0, 6'd1, "wr_iss7"};
    vecs[3]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b1, 5'd0,  1'b0, 5'd0,  5'd7, 32'h0,        1'b0, 32'h1234,     1'b1, 6'd1, "zero_addr"};
    vecs[4]  = '{1'b1, 5'd7,  32'h55,       1'b0, 5'd0,  1'b0, 5'd7,  5'd0, 32'h55,       1'b0, 32'h0,        1'b0, 6'd0, "clr7"};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd4, 32'h3,        1'b1, 32'h4,        1'b0, 6'd1, "iss3"};
    vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  1'b0, 5'd3,  5'd4, 32'h3,        1'b1, 32'h4,        1'b1, 6'd2, "iss4"};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd9,  1'b0, 5'd9,  5'd4, 32'h9,        1'b1, 32'h4,        1'b1, 6'd3, "iss9"};
    vecs[8]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 1'b1, 5'd10, 5'd9, 32'hA,        1'b0, 32'h9,        1'b0, 6'd0, "flush_iss10"};
    vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  1'b0, 5'd3,  5'd9, 32'h3,        1'b1, 32'h9,        1'b0, 6'd1, "reiss3"};
    vecs[10] = '{1'b1, 5'd3,  32'h77,       1'b0, 5'd0,  1'b1, 5'd3,  5'd4, 32'h77,       1'b0, 32'h4,        1'b0, 6'd0, "flush_wr3"};
    vecs[11] = '{1'b1, 5'd20, 32'hCAFE0000, 1'b0, 5'd0,  1'b0, 5'd20, 5'd3, 32'hCAFE0000, 1'b0, 32'h77,       1'b0, 6'd0, "wr_nonbusy"};

    // reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_pend", 32'(pend_cnt), 32'd0);
    chk("reset_hazard", 32'(hazard), 32'd0);
    for (int a = 0; a < 32; a++) begin
      rd_addr[4:0] = 5'(a);
      #1;
      chk("reset_data", rd_data[31:0], 32'(a));
      chk("reset_busy", 32'(rd_busy[0]), 32'd0);
    end

    // table-driven sequence
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
      iss_en = vecs[i].ie; iss_addr = vecs[i].ia; flush = vecs[i].fl;
      rd_addr = {vecs[i].r1, vecs[i].r0};
      @(posedge clk);
      #1;
      wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
      @(negedge clk);
      chk({vecs[i].name, "_d0"}, rd_data[31:0], vecs[i].d0);
      chk({vecs[i].name, "_b0"}, 32'(rd_busy[0]), 32'(vecs[i].b0));
      chk({vecs[i].name, "_d1"}, rd_data[63:32], vecs[i].d1);
      chk({vecs[i].name, "_b1"}, 32'(rd_busy[1]), 32'(vecs[i].b1));
      chk({vecs[i].name, "_hazard"}, 32'(hazard), 32'(vecs[i].b0 | vecs[i].b1));
      chk({vecs[i].name, "_pend"}, 32'(pend_cnt), 32'(vecs[i].pc));
    end

    // same-cycle visibility of a write to reg 12 (still holds 12)
    @(negedge clk);
    rd_addr = {5'd0, 5'd12};
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'hA5A5A5A5;
    #2;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("byp12_data_pre", rd_data[31:0], 32'hA5A5A5A5);
`else
    chk("byp12_data_pre", rd_data[31:0], 32'hC);
`endif
    chk("byp12_busy_pre", 32'(rd_busy[0]), 32'd0);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    @(negedge clk);
    chk("byp12_data_post", rd_data[31:0], 32'hA5A5A5A5);

    // issue and write reg 13 in the same cycle: new owner keeps it busy
    wr_en = 1'b1; wr_addr = 5'd13; wr_data = 32'h13131313;
    iss_en = 1'b1; iss_addr = 5'd13;
    rd_addr = {5'd12, 5'd13};
    #2;
`ifdef REG_FILE_SB_BYPASS_EN
    chk("byp13_data_pre", rd_data[31:0], 32'h13131313);
    chk("byp13_busy_pre", 32'(rd_busy[0]), 32'd1);
`else
    chk("byp13_data_pre", rd_data[31:0], 32'hD);
    chk("byp13_busy_pre", 32'(rd_busy[0]), 32'd0);
`endif
    @(posedge clk);
    #1;
    wr_en = 1'b0; iss_en = 1'b0;
    @(negedge clk);
    chk("byp13_data_post", rd_data[31:0], 32'h13131313);
    chk("byp13_busy_post", 32'(rd_busy[0]), 32'd1);
    chk("byp13_pend_post", 32'(pend_cnt), 32'd1);

    // asynchronous reset mid-operation
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_pend", 32'(pend_cnt), 32'd0);
    chk("midrst_data13", rd_data[31:0], 32'hD);
    chk("midrst_busy13", 32'(rd_busy[0]), 32'd0);
    chk("midrst_data12", rd_data[63:32], 32'hC);
    @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 32; i++) begin
      m_reg[i] = 32'(i);
      m_busy[i] = 1'b0;
    end

    // randomized traffic against the reference model
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      wr_en = ($urandom_range(0, 99) < 50);
      wr_addr = 5'($urandom_range(0, 31));
      wr_data = $urandom;
      iss_en = ($urandom_range(0, 99) < 55);
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      flush = ($urandom_range(0, 99) < 5);
      a0 = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
      rd_addr = {a1, a0};
      #2;
      e0 = m_reg[a0]; eb0 = m_busy[a0];
      e1 = m_reg[a1]; eb1 = m_busy[a1];
`ifdef REG_FILE_SB_BYPASS_EN
      if (wr_en && wr_addr != 0 && wr_addr == a0) begin
        e0 = wr_data; eb0 = iss_en && iss_addr == wr_addr;
      end
      if (wr_en && wr_addr != 0 && wr_addr == a1) begin
        e1 = wr_data; eb1 = iss_en && iss_addr == wr_addr;
      end
`endif
      chk("rnd_d0", rd_data[31:0], e0);
      chk("rnd_b0", 32'(rd_busy[0]), 32'(eb0));
      chk("rnd_d1", rd_data[63:32], e1);
      chk("rnd_b1", 32'(rd_busy[1]), 32'(eb1));
      chk("rnd_hazard", 32'(hazard), 32'(eb0 | eb1));
      @(posedge clk);
      if (wr_en && wr_addr != 0) begin
        m_reg[wr_addr] = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
      if (flush) for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
      #1;
      chk("rnd_pend", 32'(pend_cnt), 32'(m_pending()));
    end

    wr_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
- Parametrised register file with N combinational read ports, one synchronous write port, and an integrated per-register scoreboard (busy bits).
- Sits between decode/issue and writeback in the pipelined core.
- Issue marks a destination register pending; writeback stores data and clears pending.
- Read ports report operand data plus a busy flag; the block raises a hazard stall when any read port is busy.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers (power of 2, >=2); AW = $clog2(NREGS).
- NREAD, 2, number of read ports (1..4).
- INIT_INDEX, 1, 1: register i resets to value i (zero-extended to XLEN); 0: all registers reset to 0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- rd_addr  in  NREAD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NREAD*XLEN  read data; port k uses bits [k*XLEN +: XLEN].
- rd_busy  out  NREAD  port k's register has a pending write.
- hazard  out  1  OR of rd_busy.
- wr_en  in  1  writeback strobe.
- wr_addr  in  AW  writeback destination.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue strobe: mark iss_addr pending.
- iss_addr  in  AW  destination of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (register data kept).
- pend_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Reset (reset=0, asynchronous):
  - reg[i] = INIT_INDEX ? i : 0, except reg[0] = 0 always.
  - All busy bits 0; pend_cnt = 0; hazard = 0.
- Register 0:
  - Reads always return 0 with busy 0.
  - Writes and issues to address 0 are ignored.
  - busy[0] is hardwired 0.
- Read:
  - Combinational, zero latency: rd_data[k] = reg[rd_addr[k]] and rd_busy[k] = busy[rd_addr[k]].
  - Subject to the optional bypass described below.
- Write:
  - On posedge clk with wr_en=1 and wr_addr!=0: reg[wr_addr] <= wr_data and busy[wr_addr] <= 0.
- Issue:
  - On posedge clk with iss_en=1 and iss_addr!=0: busy[iss_addr] <= 1.
  - Issuing to an already-busy register leaves it busy; there is no counting of multiple outstanding writes.
- Simultaneous wr_en and iss_en to the same nonzero address:
  - Data is written and busy ends at 1 (the new instruction owns the register).
  - Issue has priority over clear.
- Writes to different addresses are independent; both update in the same cycle.
- Write to a non-busy register: data is written and busy stays 0 (no error).
- flush:
  - On posedge clk: all busy bits <= 0.
  - flush has priority over a same-cycle iss_en, so the issue is dropped.
  - A same-cycle wr_en still writes data.
- pend_cnt:
  - A registered population count of the busy bits, updated in the same edge as the busy bits, so it always equals the popcount of the current busy vector.
  - Range 0..NREGS-1.
- hazard: combinational from rd_busy; there is no registered stall.
- Reset mid-operation: all pending state is lost; register contents return to their init values.

Optional Feature:
- Macro: REG_FILE_SB_BYPASS_EN.
- Defined:
  - If wr_en=1, wr_addr!=0 and wr_addr==rd_addr[k], then rd_data[k]=wr_data in the same cycle (write-to-read forwarding).
  - rd_busy[k]=0 for that port, unless iss_en=1 with iss_addr==wr_addr in the same cycle, in which case rd_busy[k]=1.
- Not defined:
  - rd_data[k] returns the pre-write register value and rd_busy[k] reflects the registered busy bit.
  - The new value and cleared busy become visible the cycle after the write edge.

Test Plan:
- Reset with INIT_INDEX=1, release, read addresses 0..31 on port 0 -> rd_data = 0,1,...,31; all rd_busy=0; pend_cnt=0.
- iss_en addr 5 at edge n; read port1 addr 5 at n+1 -> rd_busy[1]=1, hazard=1, pend_cnt=1; wr_en addr 5 data 0xDEADBEEF at edge n+2 -> at n+2+ rd_data=0xDEADBEEF, busy 0, pend_cnt=0.
- Same-edge iss_en and wr_en both addr 7, data 0x1234 -> reg7=0x1234, busy[7]=1, pend_cnt=1.
- wr_en addr 0 data 0xFFFFFFFF and iss_en addr 0 -> rd_data for addr 0 stays 0, busy 0, pend_cnt unchanged.
- Issue addrs 3, 4, 9 on three edges (pend_cnt=3), then flush with iss_en addr 10 on the same edge -> pend_cnt=0, busy[10]=0; register data unchanged.
- With REG_FILE_SB_BYPASS_EN: wr_en addr 12 data 0xA5A5A5A5 while port0 reads 12 -> rd_data[0]=0xA5A5A5A5 before the edge; without the macro -> old value 0xC until after the edge.
